// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over XLEN cycles, with magnitude conversion and sign fix-up.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   quo;
    logic [XLEN:0]     rem;

    // operand decode on the raw inputs, only consumed on the accepting edge
    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic            div_zero, ovf, special, accept, last;

    always_comb begin
        is_div      = funct3[2];
        a_signed    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed    = is_div ? ~funct3[0] : ~funct3[1];
        a_neg       = a_signed & a[XLEN-1];
        b_neg       = b_signed & b[XLEN-1];
        abs_a       = a_neg ? -a : a;
        abs_b       = b_neg ? -b : b;
        div_zero    = is_div && (b == '0);
        ovf         = is_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special     = div_zero | ovf;
        // on overflow the quotient equals a (the most negative value)
        if (div_zero) special_res = funct3[1] ? a : '1;
        else          special_res = funct3[1] ? '0 : a;
    end

    // one iteration of each datapath; both run every CALC cycle
    logic [XLEN:0]     mul_sum, rem_sh, diff, rem_nxt;
    logic [2*XLEN-1:0] mul_nxt, prod;
    logic [XLEN-1:0]   quo_nxt, q_fin, r_fin, res_fin;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_nxt = {mul_sum, acc[XLEN-1:1]};
        rem_sh  = {rem[XLEN-1:0], quo[XLEN-1]};
        diff    = rem_sh - {1'b0, mag_b};
        rem_nxt = diff[XLEN] ? rem_sh : diff;
        quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};
        prod    = neg_q ? -mul_nxt : mul_nxt;
        q_fin   = neg_q ? -quo_nxt : quo_nxt;
        r_fin   = neg_r ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
        if (op[2])              res_fin = op[1] ? r_fin : q_fin;
        else if (op[1:0] == '0) res_fin = prod[XLEN-1:0];
        else                    res_fin = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: begin
                last = (cnt == CW'(XLEN - 1));
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            quo    <= '0;
            rem    <= '0;
            result <= '0;
        end else if (accept) begin
            cnt   <= '0;
            op    <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            mag_a <= abs_a;
            mag_b <= abs_b;
            acc   <= {{XLEN{1'b0}}, abs_b};
            quo   <= abs_a;
            rem   <= '0;
            if (special) result <= special_res;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            acc <= mul_nxt;
            quo <= quo_nxt;
            rem <= rem_nxt;
            if (last) result <= res_fin;
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ix = $signed(x);
        iy = $signed(y);
        case (f)
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ix / iy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ix % iy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // called at a negedge; acceptance happens on the following posedge
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        funct3 = f; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        funct3 = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    // counts negedge samples until done; optionally pokes start mid-CALC
    task automatic wait_done(input int intr, output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
            if (intr != 0 && lat == intr) begin
                start = 1'b1; funct3 = 3'd5; a = 32'd1000; b = 32'd3;
            end else start = 1'b0;
            if (lat > 60) begin
                check("timeout", 32'(lat), 32'd33);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input int intr);
        int lat, bcnt;
        issue(f, x, y);
        wait_done(intr, lat, bcnt);
        check({tag, ".result"}, result, ref_op(f, x, y));
        check({tag, ".latency"}, 32'(lat), 32'(ref_lat(f, x, y)));
        check({tag, ".busy_cycles"}, 32'(bcnt), (ref_lat(f, x, y) == 1) ? 32'd0 : 32'd32);
    endtask

    task automatic end_op(input string tag);
        @(negedge clk);
        check({tag, ".done_single"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int dcnt;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        #12;
        check("reset.busy", {31'b0, busy}, 32'd0);
        check("reset.done", {31'b0, done}, 32'd0);
        check("reset.result", result, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);                 end_op("mul");
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);        end_op("mulh");
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);       end_op("mulhu");
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);              end_op("mulhsu");
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);                 end_op("div");
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);                 end_op("rem");
        run_op("divu", 3'd5, 32'd100, 32'd7, 0);                      end_op("divu");
        run_op("remu", 3'd7, 32'd100, 32'd7, 0);                      end_op("remu");
        run_op("divu0", 3'd5, 32'd5, 32'd0, 0);                       end_op("divu0");
        run_op("rem0", 3'd6, 32'd5, 32'd0, 0);                        end_op("rem0");
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);      end_op("divovf");
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);      end_op("removf");

        // start during CALC must be ignored
        run_op("ignore", 3'd0, 32'd123, 32'd456, 5);                  end_op("ignore");

        // start held in DONE: second op follows with no IDLE cycle
        run_op("b2b1", 3'd4, 32'hFFFF_FF9C, 32'd7, 0);
        run_op("b2b2", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0);        end_op("b2b2");

        // asynchronous reset mid-CALC
        issue(3'd0, 32'd9, 32'd11);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.busy", {31'b0, busy}, 32'd0);
        check("arst.done", {31'b0, done}, 32'd0);
        check("arst.result", result, 32'd0);
        @(negedge clk) rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("arst.no_done", 32'(dcnt), 32'd0);
        run_op("post_rst", 3'd5, 32'hDEAD_BEEF, 32'd17, 0);           end_op("post_rst");

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, 0);
            end_op($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
